ones_checksum_acc: RTL and testbench
====================================

ONES_CHECKSUM_ACC -- requirements
Module: ones_checksum_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data word width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_data, input, WIDTH, the operand word to accumulate.
REQ-005 SHALL have port in_valid, input, 1, asserted when in_data and in_last are valid.
REQ-006 SHALL have port in_last, input, 1, marking the final word of a packet.
REQ-007 SHALL have port in_ready, output, 1, asserted when a word can be accepted.
REQ-008 SHALL have port out_sum, output, WIDTH, the ones'-complement sum of the packet.
REQ-009 SHALL have port out_check, output, WIDTH, the checksum, equal to the bitwise inverse of out_sum.
REQ-010 SHALL have port out_count, output, 8, the number of words in the packet, saturating.
REQ-011 SHALL have port out_valid, output, 1, asserted while the packet result is held.
REQ-012 SHALL have port out_ready, input, 1, the downstream acceptance of the result.

Function
REQ-013 SHALL implement a two-state FSM with states ACCUM and DONE.
REQ-014 SHALL drive in_ready=1 and out_valid=0 in ACCUM, and in_ready=0 and out_valid=1 in DONE.
REQ-015 SHALL accept a word only on a cycle with in_valid=1 and in_ready=1.
REQ-016 On acceptance, SHALL update acc <= oc_add(acc, in_data). oc_add is the WIDTH-bit sum with the carry-out added back into bit 0. A second carry is impossible and SHALL be ignored.
REQ-017 On acceptance, SHALL increment the count register. It saturates at 255 with no wrap.
REQ-018 On acceptance with in_last=1, SHALL register the updated sum and count into the output registers and move to DONE. out_valid therefore rises exactly one cycle after the last-word handshake.
REQ-019 SHALL hold out_sum, out_check and out_count stable for every cycle in DONE.
REQ-020 In DONE with out_ready=1, SHALL return to ACCUM on the next edge. At that edge, acc and count SHALL be cleared to 0, and in_ready rises that same edge.
REQ-021 While in DONE, SHALL ignore in_valid, in_data and in_last.
REQ-022 A packet consisting of a single word with in_last=1 SHALL produce out_sum equal to that word and out_count=1.
REQ-023 SHALL preserve negative zero. The all-ones result SHALL appear as all-ones and SHALL NOT be normalised to zero.
REQ-024 Cycles with in_valid=0 in ACCUM SHALL leave acc and count unchanged.

Reset
REQ-025 While reset=1 at a clock edge, SHALL enter ACCUM and clear acc, count, out_sum and out_count to 0.
REQ-026 After reset, out_check SHALL read all-ones, out_valid SHALL be 0 and in_ready SHALL be 1 from the first cycle after reset.
REQ-027 Reset mid-packet or in DONE SHALL discard all partial or held results, and no out_valid pulse SHALL occur for the aborted packet.
REQ-028 Reset SHALL take priority over a simultaneous handshake on either port.

Structure
REQ-029 SHALL instantiate one combinational sub-module, oc_add4_eac, a WIDTH-parameterised end-around-carry adder with ports a, b and sum.
REQ-030 The state encoding (ACCUM, DONE) and the count saturation constant 255 SHALL live in the shared package ones_pkg.
REQ-031 SHALL contain no latches, and SHALL contain no combinational path from in_* inputs to out_* outputs.

Verification (WIDTH=4)
REQ-032 Words 3, 5, 9 (last), back-to-back -> out_sum=0010, out_check=1101, out_count=3, with out_valid one cycle after the third handshake.
REQ-033 Words F, 1 (last) -> end-around carry gives out_sum=0001, out_check=1110, out_count=2.
REQ-034 Single word 0 (last) -> out_sum=0000, out_check=1111, out_count=1. Words F, 0 (last) -> out_sum=1111 (negative zero preserved).
REQ-035 Result held with out_ready=0 for 3 cycles while in_valid=1 -> outputs stable and in_ready=0 throughout. Then out_ready=1 for 1 cycle -> in_ready=1 on the next cycle, and the next packet (word 6, last) gives out_sum=0110.
REQ-036 Words 7, 2, then reset for 1 cycle, then word 6 (last) -> no out_valid before the reset, and the result is out_sum=0110, out_count=1.
REQ-037 A 300-word packet of all 0 -> out_count=255 (saturated) and out_sum=0000.

Source files
------------

// File: rtl/ones_pkg.sv
// Shared definitions for the ones'-complement checksum accumulator:
// FSM state encoding and the packet word-count saturation limit.
package ones_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [7:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/oc_add4_eac.sv
// Combinational ones'-complement adder: WIDTH-bit sum with the carry-out
// folded back into bit 0 (end-around carry).
module oc_add4_eac #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  // Adding the carry back cannot carry again: the low part is at most 2^WIDTH-2 when carry=1.
  assign sum = raw[WIDTH-1:0] + WIDTH'(raw[WIDTH]);

endmodule

// File: rtl/ones_checksum_acc.sv
// Accumulates a packet of words into a ones'-complement sum, then holds the
// sum, its inverse (checksum) and a saturating word count until accepted.
module ones_checksum_acc
  import ones_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_check,
  output logic [7:0]       out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] out_sum_reg, out_sum_next;
  logic [7:0]       count_reg, count_next;
  logic [7:0]       out_count_reg, out_count_next;
  logic [WIDTH-1:0] sum_calc;
  logic [7:0]       count_inc;

  oc_add4_eac #(.WIDTH(WIDTH)) u_eac (
    .a   (acc_reg),
    .b   (in_data),
    .sum (sum_calc)
  );

  assign count_inc = (count_reg == COUNT_MAX) ? count_reg : count_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      count_reg     <= '0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      out_sum_reg   <= out_sum_next;
      out_count_reg <= out_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    out_sum_next   = out_sum_reg;
    out_count_next = out_count_reg;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next   = sum_calc;
          count_next = count_inc;
          if (in_last) begin
            out_sum_next   = sum_calc;
            out_count_next = count_inc;
            state_next     = DONE;
          end
        end
      end
      DONE: begin
        // Inputs are ignored here; the held result only leaves on out_ready.
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCUM;
          acc_next   = '0;
          count_next = '0;
        end
      end
    endcase
  end

  assign out_sum   = out_sum_reg;
  assign out_check = ~out_sum_reg;
  assign out_count = out_count_reg;

endmodule

// File: tb/tb_ones_checksum_acc.sv
// Directed bench for ones_checksum_acc (WIDTH=4) with a per-cycle reference model.
module tb_ones_checksum_acc;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] out_sum;
  logic [3:0] out_check;
  logic [7:0] out_count;
  logic       out_valid;
  logic       out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit started   = 1'b0;

  // Reference model state, kept as plain integers.
  bit m_done  = 1'b0;
  int m_acc   = 0;
  int m_cnt   = 0;
  int m_sum   = 0;
  int m_count = 0;

  ones_checksum_acc #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_check (out_check),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Ones'-complement addition in arithmetic terms: a sum of 16 or more wraps modulo 15.
  function automatic int ref_add(int a, int b);
    int s;
    s = a + b;
    if (s > 15) s = s - 15;
    return s;
  endfunction

  function automatic int ref_inc(int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_done  <= 1'b0;
      m_acc   <= 0;
      m_cnt   <= 0;
      m_sum   <= 0;
      m_count <= 0;
    end else if (!m_done) begin
      if (in_valid) begin
        m_acc <= ref_add(m_acc, int'(in_data));
        m_cnt <= ref_inc(m_cnt);
        if (in_last) begin
          m_done  <= 1'b1;
          m_sum   <= ref_add(m_acc, int'(in_data));
          m_count <= ref_inc(m_cnt);
        end
      end
    end else if (out_ready) begin
      m_done <= 1'b0;
      m_acc  <= 0;
      m_cnt  <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(!m_done));
      chk("out_valid", int'(out_valid), int'(m_done));
      if (m_done) begin
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_check", int'(out_check), 15 - m_sum);
        chk("out_count", int'(out_count), m_count);
      end
    end
  end

  // Drive one word; called just after a rising edge, returns just after the next.
  task automatic send(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be visible in the cycle right after the last handshake.
  task automatic expect_result(input string name, input int s, input int c);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'(out_sum), s);
    chk({name, "_check"}, int'(out_check), 15 - s);
    chk({name, "_count"}, int'(out_count), c);
    chk({name, "_model_sum"}, m_sum, s);
    $display("pkt %s: sum=%b check=%b count=%0d", name, out_sum, out_check, out_count);
  endtask

  task automatic release_result();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_check", int'(out_check), 15);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    @(posedge clk);
    #1;

    send(4'h3, 1'b0); send(4'h5, 1'b0); send(4'h9, 1'b1);
    expect_result("w359", 2, 3);
    release_result();

    send(4'hF, 1'b0); send(4'h1, 1'b1);
    expect_result("wF1", 1, 2);
    release_result();

    send(4'h0, 1'b1);
    expect_result("w0", 0, 1);
    release_result();

    send(4'hF, 1'b0); send(4'h0, 1'b1);
    expect_result("wF0_negzero", 15, 2);
    release_result();

    // Idle cycles mid-packet leave the partial sum untouched.
    send(4'h3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(4'h5, 1'b1);
    expect_result("gap35", 8, 2);

    // Hold with out_ready low while upstream keeps offering a word.
    in_valid = 1'b1;
    in_data  = 4'hA;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_sum", int'(out_sum), 8);
      chk("hold_count", int'(out_count), 2);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", int'(in_ready), 1);
    send(4'h6, 1'b1);
    expect_result("after_hold6", 6, 1);
    release_result();

    // Reset mid-packet discards the partial sum.
    send(4'h7, 1'b0); send(4'h2, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(4'h6, 1'b1);
    expect_result("abort72_6", 6, 1);

    // Reset in DONE with a simultaneous handshake offer: reset wins.
    in_valid  = 1'b1;
    in_data   = 4'h5;
    in_last   = 1'b1;
    out_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_prio_out_valid", int'(out_valid), 0);
    chk("rst_prio_in_ready", int'(in_ready), 1);
    chk("rst_prio_sum", int'(out_sum), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) send(4'h0, (i == 299) ? 1'b1 : 1'b0);
    expect_result("zeros300_sat", 0, 255);
    release_result();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
